stream_out_framer: RTL and testbench

Downstream stage of the BRAM stream slave output port. It consumes the 128-bit result stream, buffers it in a small FIFO, and re-frames it into AXI4-Stream packets whose length comes from a per-transfer length command. It drives exact tlast/tkeep toward the DMA S2MM channel and flags any mismatch between upstream tlast and the commanded length.

---
 rtl/stream_out_framer.sv | 151 +++++++++++++++
 tb/tb_stream_out_framer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_out_framer.sv
// Re-frames a buffered 128-bit result stream into AXI4-Stream packets sized by a per-transfer length command.
// Latency: one cycle from an accepted input beat to m_tvalid when the output is idle.
// Backpressure: s_tready drops when the FIFO is full or the commanded beats are all in. Optional byte-enable feature: STREAM_OUT_FRAMER_TKEEP_EN.
module stream_out_framer #(
   parameter int DATA_W     = 128,
   parameter int FIFO_DEPTH = 16,
   parameter int LEN_W      = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [LEN_W-1:0]    cmd_len,
   input  logic                cmd_valid,
   output logic                cmd_ready,
`ifdef STREAM_OUT_FRAMER_TKEEP_EN
   input  logic [DATA_W/8-1:0] cmd_last_keep,
`endif
   input  logic [DATA_W-1:0]   s_tdata,
   input  logic                s_tvalid,
   output logic                s_tready,
   input  logic                s_tlast,
   output logic [DATA_W-1:0]   m_tdata,
   output logic                m_tvalid,
   input  logic                m_tready,
   output logic [DATA_W/8-1:0] m_tkeep,
   output logic                m_tlast,
   output logic                busy,
   output logic                err_len
);

   localparam int KW = DATA_W / 8;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]       state;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] in_cnt;
   logic             rdy_en;

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr_nxt;
   logic [PW-1:0]    rd_ptr_nxt;
   logic [DATA_W:0]  mem [FIFO_DEPTH];
   logic [DATA_W:0]  head;

   logic full;
   logic push;
   logic pop;
   logic last_tag;

   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign cmd_ready = (state == S_IDLE) && rdy_en;
   assign s_tready  = (state == S_RUN) && !full && (in_cnt < len);
   assign push      = s_tvalid && s_tready;
   assign pop       = m_tvalid && m_tready;
   assign last_tag  = (in_cnt == len - LEN_W'(1));
   assign busy      = (state != S_IDLE);

   assign wr_ptr_nxt = wr_ptr + PW'(push);
   assign rd_ptr_nxt = rd_ptr + PW'(pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         len     <= '0;
         in_cnt  <= '0;
         err_len <= 1'b0;
         rdy_en  <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         case (state)
            S_IDLE: begin
               if (cmd_ready && cmd_valid) begin
                  if (cmd_len == '0) begin
                     err_len <= 1'b1;
                  end else begin
                     len     <= cmd_len;
                     in_cnt  <= '0;
                     err_len <= 1'b0;
                     state   <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (push) begin
                  in_cnt <= in_cnt + LEN_W'(1);
                  // upstream tlast is only audited; framing follows the command
                  if (s_tlast != last_tag) err_len <= 1'b1;
                  if (last_tag) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (pop && m_tlast) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {last_tag, s_tdata};
   end

   // The output register mirrors the FIFO head; bypass when the head is being written this cycle.
   always_comb begin
      head = mem[rd_ptr_nxt[AW-1:0]];
      if (push && (rd_ptr_nxt == wr_ptr)) head = {last_tag, s_tdata};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tlast  <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr_nxt;
         rd_ptr   <= rd_ptr_nxt;
         m_tvalid <= (wr_ptr_nxt != rd_ptr_nxt);
         if (wr_ptr_nxt != rd_ptr_nxt) begin
            m_tdata <= head[DATA_W-1:0];
            m_tlast <= head[DATA_W];
         end else begin
            m_tlast <= 1'b0;
         end
      end
   end

`ifdef STREAM_OUT_FRAMER_TKEEP_EN
   logic [KW-1:0] keep_l;

   always_ff @(posedge clk) begin
      if (rst) begin
         keep_l <= '1;
      end else if (cmd_ready && cmd_valid && (cmd_len != '0)) begin
         keep_l <= cmd_last_keep;
      end
   end

   // A zero keep would describe an empty beat, so it means full width.
   assign m_tkeep = (m_tlast && (keep_l != '0)) ? keep_l : {KW{1'b1}};
`else
   assign m_tkeep = {KW{1'b1}};
`endif

endmodule

// File: tb/tb_stream_out_framer.sv
// Randomized bench for stream_out_framer against a queue-based packet model checked every cycle.
module tb_stream_out_framer;
   localparam int DW    = 128;
   localparam int KW    = DW / 8;
   localparam int DEPTH = 16;
   localparam int LW    = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [LW-1:0] cmd_len = '0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
`ifdef STREAM_OUT_FRAMER_TKEEP_EN
   logic [KW-1:0] cmd_last_keep = '1;
`endif
   logic [DW-1:0] s_tdata = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic          s_tlast = 1'b0;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tready = 1'b0;
   logic [KW-1:0] m_tkeep;
   logic          m_tlast;
   logic          busy;
   logic          err_len;

   stream_out_framer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .LEN_W(LW)) dut (
      .clk(clk), .rst(rst),
      .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
`ifdef STREAM_OUT_FRAMER_TKEEP_EN
      .cmd_last_keep(cmd_last_keep),
`endif
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tkeep(m_tkeep), .m_tlast(m_tlast),
      .busy(busy), .err_len(err_len)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
      logic [KW-1:0] k;
   } beat_t;

   int total = 0;
   int bad   = 0;

   // packet-level model: idle / collecting / draining, plus the queue of beats owed downstream
   beat_t         q[$];
   bit            model_on = 0;
   int            mode = 0;
   int            mlen = 0;
   int            min = 0;
   logic          merr = 1'b0;
   logic          mrdy = 1'b0;
   logic [KW-1:0] mkeep = '1;
   int            acc_cnt = 0;
   logic [DW-1:0] pop_d[$];
   logic          pop_l[$];
   logic [KW-1:0] pop_k[$];

   bit    exp_cr, exp_sr, exp_mv, do_pop, do_push, pl, tag;
   beat_t b;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tmo(input string nm);
      total++;
      bad++;
      $display("FAIL %s: wait expired at %0t", nm, $time);
   endtask

   always @(negedge clk) begin
      exp_cr = (mode == 0) && mrdy;
      exp_sr = (mode == 1) && (q.size() < DEPTH) && (min < mlen);
      exp_mv = (q.size() > 0);
      if (model_on) begin
         chk("cmd_ready", DW'(cmd_ready), DW'(exp_cr));
         chk("s_tready", DW'(s_tready), DW'(exp_sr));
         chk("m_tvalid", DW'(m_tvalid), DW'(exp_mv));
         chk("busy", DW'(busy), DW'(mode != 0));
         chk("err_len", DW'(err_len), DW'(merr));
         if (exp_mv) begin
            chk("m_tdata", m_tdata, q[0].d);
            chk("m_tlast", DW'(m_tlast), DW'(q[0].l));
            chk("m_tkeep", DW'(m_tkeep), DW'(q[0].k));
         end
      end
      if (rst) begin
         q.delete();
         mode = 0; mlen = 0; min = 0; merr = 1'b0; mrdy = 1'b0; mkeep = '1;
         model_on = 1;
      end else if (model_on) begin
         do_pop  = exp_mv && m_tready;
         do_push = s_tvalid && exp_sr;
         pl = 0;
         if (do_pop) begin
            pl = q[0].l;
            pop_d.push_back(q[0].d);
            pop_l.push_back(q[0].l);
            pop_k.push_back(m_tkeep);
            void'(q.pop_front());
         end
         if (exp_cr && cmd_valid) begin
            if (cmd_len == 0) merr = 1'b1;
            else begin
               mlen = int'(cmd_len); min = 0; merr = 1'b0; mode = 1;
`ifdef STREAM_OUT_FRAMER_TKEEP_EN
               mkeep = cmd_last_keep;
`endif
            end
         end
         if (do_push) begin
            tag = (min == mlen - 1);
            if (s_tlast !== tag) merr = 1'b1;
            b.d = s_tdata;
            b.l = tag;
            b.k = (tag && mkeep != '0) ? mkeep : '1;
            q.push_back(b);
            min++;
            acc_cnt++;
            if (tag) mode = 2;
         end
         if (do_pop && pl && mode == 2) mode = 0;
         mrdy = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input int len, input logic [KW-1:0] keep);
      bit hs;
      int n;
      cmd_valid = 1'b1;
      cmd_len   = LW'(len);
`ifdef STREAM_OUT_FRAMER_TKEEP_EN
      cmd_last_keep = keep;
`else
      if (keep == '0) n = 0;
`endif
      n = 0;
      do begin
         @(negedge clk);
         hs = cmd_ready;
         tick();
         n++;
      end while (!hs && n < 200);
      cmd_valid = 1'b0;
      if (!hs) tmo("cmd_handshake");
   endtask

   // sends n beats; tlast marks beat plen-1, inverted additionally at index flip
   task automatic send_beats(input int n, input int plen, input int flip, input int gap, input int base);
      bit hs;
      int w;
      for (int i = 0; i < n; i++) begin
         s_tvalid = 1'b0;
         while ($urandom_range(99) < gap) tick();
         s_tvalid = 1'b1;
         s_tdata  = (base >= 0) ? DW'(base + i) : {$urandom, $urandom, $urandom, $urandom};
         s_tlast  = (i == plen - 1) ^ (i == flip);
         w = 0;
         do begin
            @(negedge clk);
            hs = s_tready;
            tick();
            w++;
         end while (!hs && w < 3000);
         if (!hs) begin
            tmo("s_handshake");
            i = n;
         end
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic drain(input int pct);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 5000) begin
         m_tready = ($urandom_range(99) < pct);
         tick();
         n++;
      end
      m_tready = 1'b0;
      if (busy !== 1'b0) tmo("drain");
   endtask

   task automatic clear_log();
      pop_d.delete();
      pop_l.delete();
      pop_k.delete();
   endtask

   int plen, flip, gap, pct, acc0;
   logic [KW-1:0] kp;

   initial begin
      repeat (2) tick();
      chk("rst_m_tvalid", DW'(m_tvalid), 0);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_m_tkeep", DW'(m_tkeep), DW'(16'hFFFF));
      chk("rst_m_tlast", DW'(m_tlast), 0);
      chk("rst_cmd_ready", DW'(cmd_ready), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("cmd_ready_first_cycle", DW'(cmd_ready), 0);
      tick();
      @(negedge clk);
      chk("cmd_ready_rise", DW'(cmd_ready), 1);
      tick();

      // basic 4-beat packet
      clear_log();
      send_cmd(4, '1);
      fork
         send_beats(4, 4, -1, 0, 1);
         drain(100);
      join
      chk("t1_count", DW'(pop_d.size()), 4);
      for (int i = 0; i < 4 && i < pop_d.size(); i++) begin
         chk("t1_data", pop_d[i], DW'(i + 1));
         chk("t1_last", DW'(pop_l[i]), DW'(i == 3));
      end
      chk("t1_err", DW'(err_len), 0);
      chk("t1_busy", DW'(busy), 0);

      // longer than the FIFO with the output stalled
      clear_log();
      send_cmd(20, '1);
      acc0 = acc_cnt;
      fork
         send_beats(20, 20, -1, 0, 100);
         begin
            repeat (30) tick();
            chk("t2_accepted_when_full", DW'(acc_cnt - acc0), 16);
            chk("t2_s_tready_full", DW'(s_tready), 0);
            drain(100);
         end
      join
      chk("t2_count", DW'(pop_d.size()), 20);
      for (int i = 0; i < 20 && i < pop_d.size(); i++) chk("t2_order", pop_d[i], DW'(100 + i));

      // early upstream tlast
      clear_log();
      send_cmd(3, '1);
      fork
         send_beats(3, 3, 1, 0, 200);
         drain(100);
      join
      chk("t3_err", DW'(err_len), 1);
      chk("t3_count", DW'(pop_l.size()), 3);
      if (pop_l.size() == 3) begin
         chk("t3_last_mid", DW'(pop_l[1]), 0);
         chk("t3_last_end", DW'(pop_l[2]), 1);
      end
      send_cmd(1, '1);
      chk("t3_err_cleared", DW'(err_len), 0);
      fork
         send_beats(1, 1, -1, 0, 300);
         drain(100);
      join

      // zero-length command
      send_cmd(0, '1);
      chk("t4_err", DW'(err_len), 1);
      chk("t4_busy", DW'(busy), 0);
      chk("t4_s_tready", DW'(s_tready), 0);

      // reset in the middle of a packet
      m_tready = 1'b0;
      send_cmd(8, '1);
      send_beats(5, 8, -1, 0, 400);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t5_m_tvalid", DW'(m_tvalid), 0);
      chk("t5_busy", DW'(busy), 0);
      chk("t5_s_tready", DW'(s_tready), 0);
      tick();
      clear_log();
      send_cmd(2, '1);
      fork
         send_beats(2, 2, -1, 0, 500);
         drain(100);
      join
      chk("t5_count", DW'(pop_d.size()), 2);
      if (pop_d.size() == 2) begin
         chk("t5_data0", pop_d[0], DW'(500));
         chk("t5_last1", DW'(pop_l[1]), 1);
      end

`ifdef STREAM_OUT_FRAMER_TKEEP_EN
      clear_log();
      send_cmd(2, 16'h00FF);
      fork
         send_beats(2, 2, -1, 0, 600);
         drain(100);
      join
      if (pop_k.size() == 2) begin
         chk("t6_keep0", DW'(pop_k[0]), DW'(16'hFFFF));
         chk("t6_keep1", DW'(pop_k[1]), DW'(16'h00FF));
         chk("t6_last1", DW'(pop_l[1]), 1);
      end else tmo("t6_count");
`endif

      // randomized packets
      for (int p = 0; p < 30; p++) begin
         plen = $urandom_range(1, 40);
         flip = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, plen - 1)) : -1;
         gap  = $urandom_range(0, 50);
         pct  = $urandom_range(30, 100);
         kp   = KW'($urandom);
         if ($urandom_range(0, 5) == 0) send_cmd(0, kp);
         send_cmd(plen, kp);
         fork
            send_beats(plen, plen, flip, gap, -1);
            drain(pct);
         join
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
